ff_div_k4_q2: RTL and testbench



---
 rtl/ff_div_k4_q2_if.sv | 22 ++
 rtl/ff_div_k4_q2.sv | 162 ++++++++++++++++
 tb/tb_ff_div_k4_q2.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ff_div_k4_q2_if.sv
// ff_div_k4_q2_if: operand/result handshake bundle for the GF(2^4) divider.
// master = producer/consumer side, slave = divider side.
interface ff_div_k4_q2_if;
    logic       inValid;
    logic       inReady;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       outValid;
    logic       outReady;
    logic [3:0] quotient;
    logic       divByZero;

    modport master (
        output inValid, dividend, divisor, outReady,
        input  inReady, outValid, quotient, divByZero
    );

    modport slave (
        input  inValid, dividend, divisor, outReady,
        output inReady, outValid, quotient, divByZero
    );
endinterface

// File: rtl/ff_div_k4_q2.sv
// ff_div_k4_q2: sequential GF(2^4) divider, quotient = a * b^-1 mod x^4+x+1.
// Default build inverts b by square-and-multiply (b^14) through one shared
// multiplier, 7 compute edges. Defining FF_DIV_INV_LUT_EN swaps the loop for
// a 16-entry inverse ROM and goes straight to the final multiply (1 edge).
// b = 0 needs no special path: b^14 and the ROM both yield 0, so quotient = 0.

// Combinational GF(2^4) multiplier, field polynomial x^4+x+1.
module ff_div_k4_q2_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    logic [6:0] p;

    // Carry-less partial products, then fold x^4..x^6 back via x^4 = x+1.
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
        y = {p[3] ^ p[6], p[2] ^ p[5] ^ p[6], p[1] ^ p[4] ^ p[5], p[0] ^ p[4]};
    end
endmodule

module ff_div_k4_q2 (
    input  logic           clk,
    input  logic           rst_n,
    ff_div_k4_q2_if.slave  bus
);
`ifdef FF_DIV_INV_LUT_EN
    typedef enum logic [1:0] {IDLE, FIN, DONE} state_t;
`else
    typedef enum logic [3:0] {IDLE, SQ1, MU1, SQ2, MU2, SQ3, MU3, FIN, DONE} state_t;
`endif

    state_t     state, state_nxt;
    logic       in_rdy, out_vld, dbz_reg;
    logic [3:0] a_reg, r_reg, q_reg;
`ifndef FF_DIV_INV_LUT_EN
    logic [3:0] x_reg;
`else
    logic [3:0] inv_b;
`endif
    logic [3:0] mul_a, mul_b, mul_y;
    logic       accept, xfer;

    // in_rdy is only ever high in IDLE, so accept implies IDLE
    assign accept        = bus.inValid & in_rdy;
    assign xfer          = out_vld & bus.outReady;
    assign bus.inReady   = in_rdy;
    assign bus.outValid  = out_vld;
    assign bus.quotient  = q_reg;
    assign bus.divByZero = dbz_reg;

`ifdef FF_DIV_INV_LUT_EN
    // Inverse ROM: b^-1 with 0 mapping to 0.
    always_comb begin
        inv_b = 4'd0;
        case (bus.divisor)
            4'd1:  inv_b = 4'd1;
            4'd2:  inv_b = 4'd9;
            4'd3:  inv_b = 4'd14;
            4'd4:  inv_b = 4'd13;
            4'd5:  inv_b = 4'd11;
            4'd6:  inv_b = 4'd7;
            4'd7:  inv_b = 4'd6;
            4'd8:  inv_b = 4'd15;
            4'd9:  inv_b = 4'd2;
            4'd10: inv_b = 4'd12;
            4'd11: inv_b = 4'd5;
            4'd12: inv_b = 4'd10;
            4'd13: inv_b = 4'd4;
            4'd14: inv_b = 4'd3;
            4'd15: inv_b = 4'd8;
            default: inv_b = 4'd0;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed compute schedule, park in DONE until the result is taken.
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef FF_DIV_INV_LUT_EN
            IDLE: if (accept) state_nxt = FIN;
`else
            IDLE: if (accept) state_nxt = SQ1;
            SQ1:  state_nxt = MU1;
            MU1:  state_nxt = SQ2;
            SQ2:  state_nxt = MU2;
            MU2:  state_nxt = SQ3;
            SQ3:  state_nxt = MU3;
            MU3:  state_nxt = FIN;
`endif
            FIN:  state_nxt = DONE;
            DONE: if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand mux for the single multiplier; FIN (a * b^-1) is the default.
    always_comb begin
        mul_a = a_reg;
        mul_b = r_reg;
`ifndef FF_DIV_INV_LUT_EN
        case (state)
            SQ1, SQ2, SQ3: begin mul_a = x_reg; mul_b = x_reg; end
            MU1, MU2, MU3: begin mul_a = r_reg; mul_b = x_reg; end
            default: ;
        endcase
`endif
    end

    ff_div_k4_q2_mul u_mul (.a(mul_a), .b(mul_b), .y(mul_y));

    // Datapath and handshake registers; x runs b^2,b^4,b^8 while r collects b^14.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_rdy  <= 1'b0;
            out_vld <= 1'b0;
            dbz_reg <= 1'b0;
            a_reg   <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
`ifndef FF_DIV_INV_LUT_EN
            x_reg   <= '0;
`endif
        end else begin
            in_rdy <= (state_nxt == IDLE);
            if (accept) begin
                a_reg   <= bus.dividend;
                dbz_reg <= (bus.divisor == 4'd0);
`ifdef FF_DIV_INV_LUT_EN
                r_reg   <= inv_b;
`else
                r_reg   <= 4'd1;
                x_reg   <= bus.divisor;
`endif
            end
            case (state)
`ifndef FF_DIV_INV_LUT_EN
                SQ1, SQ2, SQ3: x_reg <= mul_y;
                MU1, MU2, MU3: r_reg <= mul_y;
`endif
                FIN: begin
                    q_reg   <= mul_y;
                    out_vld <= 1'b1;
                end
                DONE: if (xfer) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_div_k4_q2.sv
// tb_ff_div_k4_q2: directed bench for the GF(2^4) divider.
// Honours FF_DIV_INV_LUT_EN for the expected latency.
module tb_ff_div_k4_q2;
`ifdef FF_DIV_INV_LUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 7;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ff_div_k4_q2_if bus ();

    ff_div_k4_q2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Independent shift-and-add GF(2^4) product for the sweep.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r, t;
        r = 4'd0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
        end
        return r;
    endfunction

    // Drive one operand pair, measure edges from accept to outValid, optionally consume.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit consume,
                          output logic [3:0] q, output logic dz, output int lat);
        int n;
        n = 0;
        while (bus.inReady !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        bus.dividend = a;
        bus.divisor  = b;
        bus.inValid  = 1'b1;
        @(posedge clk); #1;
        bus.inValid  = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        lat = 0;
        while (bus.outValid !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
        if (n >= 20) lat = -1;
        q  = bus.quotient;
        dz = bus.divByZero;
        if (consume) begin
            bus.outReady = 1'b1;
            @(posedge clk); #1;
            bus.outReady = 1'b0;
        end
    endtask

    task automatic test_reset;
        bus.inValid = 1'b0; bus.outReady = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.inReady !== 1'b0) begin fails++; $display("FAIL reset_inReady actual=%b expected=0", bus.inReady); end
        tests++; if (bus.outValid !== 1'b0) begin fails++; $display("FAIL reset_outValid actual=%b expected=0", bus.outValid); end
        tests++; if (bus.quotient !== 4'd0) begin fails++; $display("FAIL reset_quotient actual=%0d expected=0", bus.quotient); end
        tests++; if (bus.divByZero !== 1'b0) begin fails++; $display("FAIL reset_divByZero actual=%b expected=0", bus.divByZero); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        tests++; if (bus.inReady !== 1'b0) begin fails++; $display("FAIL reset_inReady_before_edge actual=%b expected=0", bus.inReady); end
        @(posedge clk); #1;
        tests++; if (bus.inReady !== 1'b1) begin fails++; $display("FAIL reset_inReady_after_edge actual=%b expected=1", bus.inReady); end
    endtask

    task automatic test_basic;
        logic [3:0] va[3] = '{4'd14, 4'd10, 4'd1};
        logic [3:0] vb[3] = '{4'd5,  4'd15, 4'd2};
        logic [3:0] vq[3] = '{4'd8,  4'd15, 4'd9};
        logic [3:0] q;
        logic       dz;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, q, dz, lat);
            tests++; if (q !== vq[i]) begin fails++; $display("FAIL basic_q %0d/%0d actual=%0d expected=%0d", va[i], vb[i], q, vq[i]); end
            tests++; if (dz !== 1'b0) begin fails++; $display("FAIL basic_dz %0d/%0d actual=%b expected=0", va[i], vb[i], dz); end
            tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency %0d/%0d actual=%0d expected=%0d", va[i], vb[i], lat, LAT); end
        end
    endtask

    task automatic test_zero_div;
        logic [3:0] q;
        logic       dz;
        int         lat;
        run_op(4'd3, 4'd0, 1'b1, q, dz, lat);
        tests++; if (q !== 4'd0) begin fails++; $display("FAIL zdiv_q actual=%0d expected=0", q); end
        tests++; if (dz !== 1'b1) begin fails++; $display("FAIL zdiv_dz actual=%b expected=1", dz); end
        tests++; if (lat !== LAT) begin fails++; $display("FAIL zdiv_latency actual=%0d expected=%0d", lat, LAT); end
        run_op(4'd0, 4'd7, 1'b1, q, dz, lat);
        tests++; if (q !== 4'd0) begin fails++; $display("FAIL zero_num_q actual=%0d expected=0", q); end
        tests++; if (dz !== 1'b0) begin fails++; $display("FAIL zero_num_dz actual=%b expected=0", dz); end
    endtask

    task automatic test_back_pressure;
        logic [3:0] q;
        logic       dz;
        int         lat;
        run_op(4'd14, 4'd5, 1'b0, q, dz, lat);
        tests++; if (q !== 4'd8) begin fails++; $display("FAIL bp_first_q actual=%0d expected=8", q); end
        bus.dividend = 4'd10;
        bus.divisor  = 4'd15;
        bus.inValid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.outValid !== 1'b1 || bus.quotient !== 4'd8 || bus.divByZero !== 1'b0 || bus.inReady !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall cyc=%0d actual v=%b q=%0d dz=%b rdy=%b expected v=1 q=8 dz=0 rdy=0",
                         c, bus.outValid, bus.quotient, bus.divByZero, bus.inReady);
            end
        end
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
        tests++; if (bus.outValid !== 1'b0) begin fails++; $display("FAIL bp_xfer_outValid actual=%b expected=0", bus.outValid); end
        tests++; if (bus.inReady !== 1'b1) begin fails++; $display("FAIL bp_xfer_inReady actual=%b expected=1", bus.inReady); end
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        tests++; if (bus.inReady !== 1'b0) begin fails++; $display("FAIL bp_accept_inReady actual=%b expected=0", bus.inReady); end
        lat = 0;
        while (bus.outValid !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
        tests++; if (lat !== LAT) begin fails++; $display("FAIL bp_second_latency actual=%0d expected=%0d", lat, LAT); end
        tests++; if (bus.quotient !== 4'd15) begin fails++; $display("FAIL bp_second_q actual=%0d expected=15", bus.quotient); end
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [3:0] q;
        logic       dz;
        int         lat;
        int         n;
        n = 0;
        while (bus.inReady !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        bus.dividend = 4'd3;
        bus.divisor  = 4'd0;
        bus.inValid  = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
`ifdef FF_DIV_INV_LUT_EN
        #2;
`else
        repeat (3) @(posedge clk);
        #3;
`endif
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.outValid !== 1'b0 || bus.inReady !== 1'b0 || bus.quotient !== 4'd0 || bus.divByZero !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs actual v=%b rdy=%b q=%0d dz=%b expected all 0",
                     bus.outValid, bus.inReady, bus.quotient, bus.divByZero);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.inReady !== 1'b1) begin fails++; $display("FAIL midrst_inReady actual=%b expected=1", bus.inReady); end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.outValid !== 1'b0) n++;
            @(posedge clk); #1;
        end
        tests++; if (n !== 0) begin fails++; $display("FAIL midrst_stale_outValid actual=%0d expected=0 cycles", n); end
        run_op(4'd1, 4'd2, 1'b1, q, dz, lat);
        tests++; if (q !== 4'd9 || dz !== 1'b0) begin fails++; $display("FAIL midrst_recover actual q=%0d dz=%b expected q=9 dz=0", q, dz); end
    endtask

    task automatic test_sweep;
        logic [3:0] q;
        logic       dz;
        int         lat;
        bit         ok;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), 1'b1, q, dz, lat);
                if (b == 0) ok = (q === 4'd0) && (dz === 1'b1);
                else        ok = (ref_mul(q, 4'(b)) === 4'(a)) && (dz === 1'b0);
                ok = ok && (lat == LAT);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL sweep a=%0d b=%0d actual q=%0d dz=%b lat=%0d expected q*b=a dz=%0d lat=%0d",
                             a, b, q, dz, lat, (b == 0), LAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_div();
        test_back_pressure();
        test_reset_mid_op();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "watchdog");
    end
endmodule
